// File: rtl/rms_seq_ctrl.sv
// rms_seq_ctrl -- sequencer for an external RMS datapath.
//
// Walks a window of 2**NBITS2 ADC samples into the datapath, holds the index
// at end-of-window while the datapath divides and takes the square root,
// flushes the index back to zero, then captures the returned RMS value.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle request to begin a window (ignored unless IDLE)
//   cont            : continuous mode, re-arm after every capture
//   abort           : cancel the window in RUN/SETTLE (no capture)
//   sample_valid    : ADC strobe, sample_in is the signed sample
//   rms_count       : window index to the datapath (saturates at 2**NBITS2)
//   rms_data        : last accepted sample, forwarded to the datapath
//   rms_result      : RMS value from the datapath
//   result          : last captured RMS value, result_valid pulses on update
//   busy            : high outside IDLE
//   overrun         : sticky, a strobe arrived while settling; cleared by start
//   thr_hi, thr_lo  : signal-detect thresholds
//   sig_detect      : hysteretic "result above threshold" status
//
// Build option
//   RMS_SEQ_CTRL_THRESH_EN : compiles in the sig_detect comparators. When not
//   defined, sig_detect is tied low and the thresholds are unused.

module rms_seq_ctrl #(
  parameter int NBADD      = 8,
  parameter int NBITS1     = 16,
  parameter int NBITS2     = 12,
  parameter int SETTLE_CYC = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cont,
  input  logic                     abort,
  input  logic                     sample_valid,
  input  logic signed [NBITS1-1:0] sample_in,
  output logic [NBADD+4:0]         rms_count,
  output logic signed [NBITS1-1:0] rms_data,
  input  logic signed [NBITS1-1:0] rms_result,
  output logic signed [NBITS1-1:0] result,
  output logic                     result_valid,
  output logic                     busy,
  output logic                     overrun,
  input  logic signed [NBITS1-1:0] thr_hi,
  input  logic signed [NBITS1-1:0] thr_lo,
  output logic                     sig_detect
);

  localparam int              CW  = NBADD + 5;
  localparam logic [CW-1:0]   WIN = CW'(1) << NBITS2;
  localparam int              TW  = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {IDLE, RUN, SETTLE, FLUSH, CAPTURE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmr;          // cycles spent in the current SETTLE/FLUSH
  logic          flush_abort;  // FLUSH was entered through abort: skip CAPTURE

  logic take_sample, cap_en, ovr_set, ovr_clr;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      // abort has priority over the final strobe of the window
      RUN:     if (abort) state_nxt = FLUSH;
               else if (sample_valid && rms_count == WIN - CW'(1)) state_nxt = SETTLE;
      SETTLE:  if (abort || tmr == TW'(SETTLE_CYC - 1)) state_nxt = FLUSH;
      FLUSH:   if (tmr == TW'(1)) state_nxt = flush_abort ? IDLE : CAPTURE;
      CAPTURE: state_nxt = cont ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs / datapath controls
  always_comb begin
    busy        = (state != IDLE);
    take_sample = (state == RUN) && sample_valid && !abort;
    cap_en      = (state == CAPTURE);
    ovr_set     = (state == SETTLE) && sample_valid;
    ovr_clr     = (state == IDLE) && start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr          <= '0;
      flush_abort  <= 1'b0;
      rms_count    <= '0;
      rms_data     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (state_nxt != state || !(state == SETTLE || state == FLUSH)) tmr <= '0;
      else                                                            tmr <= tmr + TW'(1);

      if (abort && (state == RUN || state == SETTLE)) flush_abort <= 1'b1;
      else if (state != FLUSH)                        flush_abort <= 1'b0;

      // count saturates at WIN; any entry to FLUSH zeroes it and it stays zero
      // through FLUSH, CAPTURE and IDLE.
      if (take_sample && rms_count != WIN) rms_count <= rms_count + CW'(1);
      else if (state_nxt == FLUSH)         rms_count <= '0;

      if (take_sample) rms_data <= sample_in;

      if (cap_en) result <= rms_result;
      result_valid <= cap_en;

      if (ovr_clr)      overrun <= 1'b0;
      else if (ovr_set) overrun <= 1'b1;
    end
  end

`ifdef RMS_SEQ_CTRL_THRESH_EN
  // hysteresis on the value being captured this cycle
  always_ff @(posedge clk) begin
    if (rst) sig_detect <= 1'b0;
    else if (cap_en) begin
      if (rms_result > thr_hi)      sig_detect <= 1'b1;
      else if (rms_result < thr_lo) sig_detect <= 1'b0;
    end
  end
`else
  logic unused_thr;
  assign unused_thr = ^{thr_hi, thr_lo};
  assign sig_detect = 1'b0;
`endif

endmodule

// File: tb/tb_rms_seq_ctrl.sv
// Bench for rms_seq_ctrl: scoreboard of expected captures, checked when
// result_valid pulses, plus directed checks of the sequencing.
module tb_rms_seq_ctrl;
  localparam int WIN    = 4096;
  localparam int SETTLE = 40;

  logic               clk = 1'b0;
  logic               rst, start, cont, abort, sample_valid;
  logic signed [15:0] sample_in, rms_result, thr_hi, thr_lo;
  logic [12:0]        rms_count;
  logic signed [15:0] rms_data, result;
  logic               result_valid, busy, overrun, sig_detect;

  rms_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .sample_valid(sample_valid), .sample_in(sample_in),
    .rms_count(rms_count), .rms_data(rms_data), .rms_result(rms_result),
    .result(result), .result_valid(result_valid), .busy(busy),
    .overrun(overrun), .thr_hi(thr_hi), .thr_lo(thr_lo), .sig_detect(sig_detect)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, last_strobe = 0, pulses = 0;
  bit busy_bad;
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

`ifdef RMS_SEQ_CTRL_THRESH_EN
  logic sd_model = 1'b0;
`endif

  // scoreboard consumer
  always @(negedge clk) begin
    if (result_valid) begin
      pulses++;
      if (exp_q.size() == 0) chk("unexpected_rv", 1, 0);
      else begin
        chk("result", result, exp_q.pop_front());
        chk("latency", cyc - last_strobe, SETTLE + 3);
`ifdef RMS_SEQ_CTRL_THRESH_EN
        if (result > thr_hi) sd_model = 1'b1;
        else if (result < thr_lo) sd_model = 1'b0;
        chk("sig_detect", sig_detect, sd_model);
`else
        chk("sig_detect", sig_detect, 0);
`endif
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic strobe(input logic [15:0] v, input int gap);
    sample_valid = 1'b1; sample_in = v;
    tick;
    sample_valid = 1'b0;
    last_strobe  = cyc;
    repeat (gap) tick;
  endtask

  // samples base..base+n-1; the window's last sample gets no gap
  task automatic run_samples(input int base, input int n, input int gap);
    for (int i = base; i < base + n; i++) begin
      logic [15:0] v;
      v = 16'(i * 7 + 3);
      strobe(v, (i == WIN - 1) ? 0 : gap);
      if (i < 2 || i == 2047 || i == WIN - 1) begin
        chk("count", rms_count, i + 1);
        chk("data", rms_data, v);
      end
    end
  endtask

  task automatic wait_rv(input bit busy_req);
    int k;
    k = 0;
    while (!result_valid && k < 200) begin
      if (busy_req && !busy) busy_bad = 1'b1;
      tick;
      k++;
    end
    if (!result_valid) chk("rv_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_count"}, rms_count, 0);
    chk({tag, "_data"}, rms_data, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_rv"}, result_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_sig"}, sig_detect, 0);
  endtask

  initial begin
    bit ok;
    rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; sample_valid = 1'b0;
    sample_in = '0; rms_result = '0;
`ifdef RMS_SEQ_CTRL_THRESH_EN
    thr_hi = 16'sd1000; thr_lo = 16'sd800;
`else
    thr_hi = '0; thr_lo = '0;
`endif
    repeat (3) tick;
    check_zero("reset");
    rst = 1'b0;

    // basic window, one strobe every 4 cycles
    rms_result = 16'h1234;
    exp_q.push_back(16'h1234);
    start = 1'b1; tick; start = 1'b0;
    chk("busy_run", busy, 1);
    run_samples(0, 100, 3);
    start = 1'b1; tick; start = 1'b0;
    chk("start_ignored", rms_count, 100);
    run_samples(100, WIN - 100, 3);
    ok = 1'b1;
    for (int k = 0; k < SETTLE; k++) begin
      if (rms_count != 13'(WIN) || !busy) ok = 1'b0;
      tick;
    end
    chk("settle_hold", ok, 1);
    chk("flush0_count", rms_count, 0);
    chk("flush0_busy", busy, 1);
    tick;
    chk("flush1_count", rms_count, 0);
    tick;
    chk("capture_rv", result_valid, 0);
    tick;
    chk("rv_pulse", result_valid, 1);
    chk("result_now", result, 16'h1234);
    tick;
    chk("rv_single", result_valid, 0);
    chk("idle_busy", busy, 0);

    // abort at sample 2000
    rms_result = 16'h5555;
    start = 1'b1; tick; start = 1'b0;
    run_samples(0, 1999, 1);
    abort = 1'b1; tick; abort = 1'b0;
    chk("abort_f0_count", rms_count, 0);
    chk("abort_f0_busy", busy, 1);
    tick;
    chk("abort_f1_busy", busy, 1);
    tick;
    chk("abort_idle", busy, 0);
    chk("abort_result", result, 16'h1234);
    repeat (60) tick;

    // abort together with the final strobe
    start = 1'b1; tick; start = 1'b0;
    run_samples(0, WIN - 1, 0);
    abort = 1'b1; sample_valid = 1'b1; tick; abort = 1'b0; sample_valid = 1'b0;
    chk("race_count", rms_count, 0);
    repeat (2) tick;
    chk("race_idle", busy, 0);
    repeat (50) tick;

    // strobe during SETTLE
    rms_result = 16'h0BEE;
    exp_q.push_back(16'h0BEE);
    start = 1'b1; tick; start = 1'b0;
    run_samples(0, WIN, 0);
    repeat (5) tick;
    sample_valid = 1'b1; tick; sample_valid = 1'b0;
    chk("overrun_set", overrun, 1);
    chk("overrun_count", rms_count, WIN);
    wait_rv(0);
    tick;
    chk("overrun_sticky", overrun, 1);

    // continuous mode, cont dropped during the third window
    cont = 1'b1;
    rms_result = 16'h0111;
    exp_q.push_back(16'h0111);
    busy_bad = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    chk("overrun_clr", overrun, 0);
    for (int w = 0; w < 3; w++) begin
      run_samples(0, 2000, 0);
      if (w == 2) cont = 1'b0;
      run_samples(2000, WIN - 2000, 0);
      wait_rv(1);
      if (w < 2) begin
        chk("cont_busy", busy, 1);
        chk("cont_restart", rms_count, 0);
        rms_result = 16'(16'h0111 * (w + 2));
        exp_q.push_back(rms_result);
      end else begin
        chk("cont_end_idle", busy, 0);
      end
    end
    chk("cont_busy_steady", busy_bad, 0);

    // reset mid-window
    rms_result = 16'h7777;
    start = 1'b1; tick; start = 1'b0;
    run_samples(0, 1500, 0);
    rst = 1'b1; tick;
    check_zero("midrst");
    rst = 1'b0; start = 1'b1; tick; start = 1'b0;
    chk("rst_start_busy", busy, 1);
    chk("rst_start_count", rms_count, 0);
    strobe(16'h0042, 0);
    chk("rst_first_count", rms_count, 1);
    abort = 1'b1; tick; abort = 1'b0;
    repeat (5) tick;

    chk("pulses", pulses, 5);
    chk("q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
